mer_meas_ctrl: RTL

//  Sequencer for the MER measurement datapath (ref level gen, err_sq_gen, err_dc_gen, symbol check).
//  On start: clears the error accumulators, waits SETTLE_SYMS symbols for the reference level to

---
 rtl/mer_meas_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: clear, settle, accumulate 2**LOG2_WIN symbols, flush, latch, done.
// Build option: define MER_CTRL_AUTO_RESTART_EN for continuous back-to-back measurement windows.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start
// S_SETTLE | accumulators held cleared while the reference level converges
// S_ACCUM  | accumulation window open, symbol errors counted
// S_FLUSH  | waiting for the datapath pipeline to drain
// S_LATCH  | capture accumulator values
// S_DONE   | results valid; wait for start (or restart automatically)
module mer_meas_ctrl #(
  parameter int SETTLE_SYMS = 1024,
  parameter int LOG2_WIN    = 18,
  parameter int PIPE_LAT    = 2,
  parameter int ACC_W       = 39,
  parameter int ERR_CNT_W   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sym_error,
  input  logic [ACC_W-1:0]     acc_sq_in,
  input  logic [ACC_W-1:0]     acc_dc_in,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [ACC_W-1:0]     sq_err_result,
  output logic [ACC_W-1:0]     dc_err_result,
  output logic [ERR_CNT_W-1:0] sym_err_count
);

  localparam int SETTLE_W = $clog2(SETTLE_SYMS + 1);
  localparam int PIPE_W   = $clog2(PIPE_LAT + 1);
  localparam int CNT_W0   = (LOG2_WIN + 1 > SETTLE_W) ? LOG2_WIN + 1 : SETTLE_W;
  localparam int CNT_W    = (CNT_W0 > PIPE_W) ? CNT_W0 : PIPE_W;

  // Down-counter reload values: terminal count is zero on a clk_en.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_SYMS - 1);
  localparam logic [CNT_W-1:0] WIN_LD    = CNT_W'((1 << LOG2_WIN) - 1);
  localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

`ifdef MER_CTRL_AUTO_RESTART_EN
  localparam bit AUTO_RESTART = 1'b1;
`else
  localparam bit AUTO_RESTART = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ACCUM, S_FLUSH, S_LATCH, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_nxt;
  logic             cnt_zero;

  assign cnt_zero = (sym_cnt == '0);

  always_comb begin
    state_nxt   = state;
    sym_cnt_nxt = sym_cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt   = S_SETTLE;
          sym_cnt_nxt = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (clk_en) begin
          if (cnt_zero) begin
            state_nxt   = S_ACCUM;
            sym_cnt_nxt = WIN_LD;
          end else begin
            sym_cnt_nxt = sym_cnt - CNT_W'(1);
          end
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (clk_en) begin
          if (cnt_zero) begin
            state_nxt   = S_FLUSH;
            sym_cnt_nxt = FLUSH_LD;
          end else begin
            sym_cnt_nxt = sym_cnt - CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (PIPE_LAT == 0) begin
          state_nxt = S_LATCH;
        end else if (clk_en) begin
          if (cnt_zero) state_nxt = S_LATCH;
          else          sym_cnt_nxt = sym_cnt - CNT_W'(1);
        end
      end
      S_LATCH: begin
        state_nxt = abort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if ((start || AUTO_RESTART) && !abort) begin
          state_nxt   = S_SETTLE;
          sym_cnt_nxt = SETTLE_LD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      sym_cnt       <= '0;
      acc_clr       <= 1'b0;
      acc_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      sq_err_result <= '0;
      dc_err_result <= '0;
      sym_err_count <= '0;
    end else begin
      state   <= state_nxt;
      sym_cnt <= sym_cnt_nxt;
      acc_clr <= (state_nxt == S_SETTLE);
      acc_en  <= (state_nxt == S_ACCUM);
      busy    <= (state_nxt inside {S_SETTLE, S_ACCUM, S_FLUSH, S_LATCH});
      done    <= (state == S_LATCH) && (state_nxt == S_DONE);

      if (state == S_LATCH && state_nxt == S_DONE) begin
        sq_err_result <= acc_sq_in;
        dc_err_result <= acc_dc_in;
        result_valid  <= 1'b1;
      end else if (state != S_IDLE && state_nxt == S_IDLE) begin
        result_valid  <= 1'b0;
      end else if (state != S_SETTLE && state_nxt == S_SETTLE && !AUTO_RESTART) begin
        result_valid  <= 1'b0;
      end

      // Saturating error count; the aborting symbol is not counted.
      if (state != S_SETTLE && state_nxt == S_SETTLE) begin
        sym_err_count <= '0;
      end else if (state == S_ACCUM && !abort && clk_en && sym_error && !(&sym_err_count)) begin
        sym_err_count <= sym_err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule
